// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for HTRANS, HRESP and HSIZE
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } trans_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01
    } resp_t;

    localparam logic [2:0] BYTE = 3'd0;
    localparam logic [2:0] HALF = 3'd1;
    localparam logic [2:0] WORD = 3'd2;

endpackage

// File: rtl/ahb_cmd_manager.sv
// ahb_cmd_manager: pipelined AHB-Lite manager turning a valid/ready command stream into single NONSEQ transfers
module ahb_cmd_manager
    import ahb_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic [AddrWidth-1:0] cmdAddr,
    input  logic                 cmdWrite,
    input  logic [2:0]           cmdSize,
    input  logic [DataWidth-1:0] cmdWData,
    output logic                 rspValid,
    output logic [DataWidth-1:0] rspData,
    output logic                 rspErr,
    output logic [AddrWidth-1:0] addr,
    output logic [1:0]           trans,
    output logic                 write,
    output logic [2:0]           size,
    output logic [DataWidth-1:0] wData,
    input  logic [DataWidth-1:0] rData,
    input  logic [1:0]           resp,
    input  logic                 ready
);

    logic                 a_valid;
    logic [AddrWidth-1:0] a_addr;
    logic                 a_write;
    logic [2:0]           a_size;
    logic [DataWidth-1:0] a_wdata;
    logic                 d_valid;
    logic                 d_write;
    logic [DataWidth-1:0] d_wdata;
    logic                 err_seen;
    logic                 advance;
    logic                 accept;
    logic                 done;
    logic                 unused_resp;

    // Only bit 0 of HRESP distinguishes OKAY from ERROR
    assign unused_resp = resp[1];

    // The A-slot drives the address phase; the IDLE slot during an error response cancels it
    assign trans    = (a_valid && !err_seen) ? NONSEQ : IDLE;
    assign addr     = a_addr;
    assign write    = a_write;
    assign size     = a_size;
    assign wData    = d_wdata;
    assign advance  = ready && !err_seen;
    assign cmdReady = !a_valid || advance;
    assign accept   = cmdValid && cmdReady;
    assign done     = d_valid && ready;

    // Pipeline slots, two-cycle error tracking and the registered response pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid   <= 1'b0;
            a_addr    <= '0;
            a_write   <= 1'b0;
            a_size    <= '0;
            a_wdata   <= '0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            d_wdata   <= '0;
            err_seen  <= 1'b0;
            rspValid  <= 1'b0;
            rspErr    <= 1'b0;
            rspData   <= '0;
        end else begin
            if (accept) begin
                a_valid <= 1'b1;
                a_addr  <= cmdAddr;
                a_write <= cmdWrite;
                a_size  <= cmdSize;
                a_wdata <= cmdWData;
            end else if (advance) begin
                a_valid <= 1'b0;
            end
            if (advance) begin
                d_valid <= a_valid;
                d_write <= a_write;
                d_wdata <= a_wdata;
            end else if (err_seen && ready) begin
                d_valid <= 1'b0;
            end
            err_seen <= err_seen ? !ready : (d_valid && !ready && resp[0]);
            rspValid <= done;
            rspErr   <= done && resp[0];
            rspData  <= (done && !d_write) ? rData : '0;
        end
    end

endmodule

// File: tb/tb_ahb_cmd_manager.sv
// tb_ahb_cmd_manager: directed self-checking bench for the pipelined AHB-Lite command manager
module tb_ahb_cmd_manager;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic [31:0] cmdAddr;
    logic        cmdWrite;
    logic [2:0]  cmdSize;
    logic [31:0] cmdWData;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rspErr;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wData;
    logic [31:0] rData;
    logic [1:0]  resp;
    logic        ready;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ahb_cmd_manager #(.AddrWidth(32), .DataWidth(32)) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddr(cmdAddr), .cmdWrite(cmdWrite),
        .cmdSize(cmdSize), .cmdWData(cmdWData),
        .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
        .addr(addr), .trans(trans), .write(write), .size(size), .wData(wData),
        .rData(rData), .resp(resp), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic cmd(input logic [31:0] a, input logic w, input logic [31:0] d);
        cmdValid = 1'b1;
        cmdAddr  = a;
        cmdWrite = w;
        cmdSize  = 3'd2;
        cmdWData = d;
    endtask

    initial begin
        reset = 1'b1; cmdValid = 1'b0; cmdAddr = '0; cmdWrite = 1'b0; cmdSize = '0;
        cmdWData = '0; rData = '0; resp = 2'b00; ready = 1'b1;
        step(); step();
        chk("rst_trans", trans, 2'b00);
        chk("rst_cmdReady", cmdReady, 1);
        chk("rst_rspValid", rspValid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wData", wData, 0);
        reset = 1'b0;
        step();

        // single write
        cmd(32'h100, 1'b1, 32'hDEADBEEF);
        #1 chk("wr_cmdReady", cmdReady, 1);
        step();
        cmdValid = 1'b0;
        #1;
        chk("wr_trans", trans, 2'b10);
        chk("wr_addr", addr, 32'h100);
        chk("wr_write", write, 1);
        chk("wr_size", size, 3'd2);
        step();
        chk("wr_trans_idle", trans, 2'b00);
        chk("wr_wData", wData, 32'hDEADBEEF);
        chk("wr_rsp_early", rspValid, 0);
        step();
        chk("wr_rspValid", rspValid, 1);
        chk("wr_rspErr", rspErr, 0);
        chk("wr_rspData", rspData, 0);
        step();
        chk("wr_rsp_pulse", rspValid, 0);

        // back-to-back reads
        cmd(32'h0, 1'b0, 32'h0);
        step();
        cmd(32'h4, 1'b0, 32'h0);
        #1 chk("rd0_trans", trans, 2'b10);
        chk("rd0_addr", addr, 32'h0);
        step();
        cmd(32'h8, 1'b0, 32'h0);
        rData = 32'h11;
        #1 chk("rd1_trans", trans, 2'b10);
        chk("rd1_addr", addr, 32'h4);
        step();
        cmdValid = 1'b0;
        rData = 32'h22;
        #1 chk("rd2_trans", trans, 2'b10);
        chk("rd2_addr", addr, 32'h8);
        chk("rd0_rspValid", rspValid, 1);
        chk("rd0_rspData", rspData, 32'h11);
        step();
        rData = 32'h33;
        chk("rd1_rspValid", rspValid, 1);
        chk("rd1_rspData", rspData, 32'h22);
        chk("rd_idle", trans, 2'b00);
        step();
        chk("rd2_rspValid", rspValid, 1);
        chk("rd2_rspData", rspData, 32'h33);
        step();
        chk("rd_done", rspValid, 0);

        // wait states in the data phase of read 0x40
        cmd(32'h40, 1'b0, 32'h0);
        step();
        cmd(32'h44, 1'b1, 32'hA5A5A5A5);
        step();
        cmdValid = 1'b0;
        ready = 1'b0;
        rData = 32'hBAD;
        #1 chk("ws0_cmdReady", cmdReady, 0);
        chk("ws0_addr", addr, 32'h44);
        chk("ws0_trans", trans, 2'b10);
        step();
        chk("ws1_cmdReady", cmdReady, 0);
        chk("ws1_addr", addr, 32'h44);
        chk("ws1_trans", trans, 2'b10);
        chk("ws1_rspValid", rspValid, 0);
        step();
        chk("ws2_addr", addr, 32'h44);
        chk("ws2_rspValid", rspValid, 0);
        ready = 1'b1;
        rData = 32'h77;
        #1 chk("ws_release_cmdReady", cmdReady, 1);
        step();
        chk("ws_rspValid", rspValid, 1);
        chk("ws_rspData", rspData, 32'h77);
        chk("ws_wData", wData, 32'hA5A5A5A5);
        chk("ws_trans_idle", trans, 2'b00);
        step();
        chk("ws_wr_rspValid", rspValid, 1);
        chk("ws_wr_rspData", rspData, 0);
        step();
        chk("ws_single", rspValid, 0);

        // two-cycle error response on write 0x200 with read 0x204 queued
        cmd(32'h200, 1'b1, 32'h1234);
        step();
        cmd(32'h204, 1'b0, 32'h0);
        step();
        cmdValid = 1'b0;
        ready = 1'b0;
        resp = 2'b01;
        #1 chk("err1_trans", trans, 2'b10);
        chk("err1_addr", addr, 32'h204);
        step();
        ready = 1'b1;
        #1 chk("err2_trans", trans, 2'b00);
        chk("err2_cmdReady", cmdReady, 0);
        step();
        resp = 2'b00;
        rData = 32'h55;
        #1 chk("err_rspValid", rspValid, 1);
        chk("err_rspErr", rspErr, 1);
        chk("reissue_trans", trans, 2'b10);
        chk("reissue_addr", addr, 32'h204);
        chk("reissue_write", write, 0);
        step();
        chk("reissue_trans_idle", trans, 2'b00);
        chk("reissue_no_rsp", rspValid, 0);
        step();
        chk("reissue_rspValid", rspValid, 1);
        chk("reissue_rspErr", rspErr, 0);
        chk("reissue_rspData", rspData, 32'h55);
        step();

        // reset during the data phase of read 0x300
        cmd(32'h300, 1'b0, 32'h0);
        step();
        cmdValid = 1'b0;
        #1 chk("mid_trans", trans, 2'b10);
        chk("mid_addr", addr, 32'h300);
        step();
        rData = 32'h99;
        reset = 1'b1;
        #1 chk("mid_rst_trans", trans, 2'b00);
        chk("mid_rst_rspValid", rspValid, 0);
        chk("mid_rst_cmdReady", cmdReady, 1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_rsp", rspValid, 0);
        end

        // idle bus
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_trans", trans, 2'b00);
            chk("idle_rspValid", rspValid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
